// File: rtl/addsub_pkg.sv
// Shared op encodings and saturation limits for the add/sub accumulator datapath.
package addsub_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam int unsigned SAT_LIM_W = 64;

    // Callers slice the low `width` bits of the result.
    function automatic logic [SAT_LIM_W-1:0] sat_max(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [SAT_LIM_W-1:0] sat_min(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/addsub_accumulator_adder.sv
// Combinational n-bit adder/subtracter; cin=1 turns x + ~y + 1 into x - y.
module addsub_accumulator_adder #(
    parameter int unsigned n = 8
) (
    input  logic [n-1:0] i_x,
    input  logic [n-1:0] i_y,
    input  logic         i_cin,
    output logic [n-1:0] o_sum,
    output logic         o_cout,
    output logic         o_overflow
);

    logic [n-1:0] w_y_eff;
    logic [n:0]   w_full;

    assign w_y_eff = i_cin ? ~i_y : i_y;
    assign w_full  = {1'b0, i_x} + {1'b0, w_y_eff} + {{n{1'b0}}, i_cin};

    assign o_sum  = w_full[n-1:0];
    assign o_cout = w_full[n];
    // Signed overflow: operands agree in sign but the sum does not.
    assign o_overflow = (i_x[n-1] == w_y_eff[n-1]) && (w_full[n-1] != i_x[n-1]);

endmodule

// File: rtl/addsub_accumulator.sv
// Handshaked accumulator stage around the add/sub unit, with optional saturation,
// sticky overflow and a saturating operation counter.
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int unsigned n     = 8,
    parameter int unsigned SAT   = 0,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [n-1:0]     y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [n-1:0]     acc,
    output logic             cout,
    output logic             overflow,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [SAT_LIM_W-1:0] SatMaxFull = sat_max(n);
    localparam logic [SAT_LIM_W-1:0] SatMinFull = sat_min(n);
    localparam logic [n-1:0]         SatMax     = SatMaxFull[n-1:0];
    localparam logic [n-1:0]         SatMin     = SatMinFull[n-1:0];
    localparam logic [CNT_W-1:0]     CntMax     = {CNT_W{1'b1}};

    logic             r_out_valid;
    logic [n-1:0]     r_acc;
    logic             r_cout;
    logic             r_overflow;
    logic             r_ovf_sticky;
    logic [CNT_W-1:0] r_op_count;

    logic             w_out_valid_nxt;
    logic [n-1:0]     w_acc_nxt;
    logic             w_cout_nxt;
    logic             w_overflow_nxt;
    logic             w_ovf_sticky_nxt;
    logic [CNT_W-1:0] w_op_count_nxt;

    logic             w_accept;
    logic [n-1:0]     w_sum;
    logic             w_add_cout;
    logic             w_add_ovf;

    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;

    addsub_accumulator_adder #(
        .n (n)
    ) u_adder (
        .i_x        (r_acc),
        .i_y        (y),
        .i_cin      (op == OP_SUB),
        .o_sum      (w_sum),
        .o_cout     (w_add_cout),
        .o_overflow (w_add_ovf)
    );

    always_comb begin
        w_acc_nxt        = r_acc;
        w_cout_nxt       = r_cout;
        w_overflow_nxt   = r_overflow;
        w_ovf_sticky_nxt = r_ovf_sticky;
        w_op_count_nxt   = r_op_count;

        if (w_accept) begin
            case (op)
                OP_ADD, OP_SUB: begin
                    // Saturation direction follows the sign of the old accumulator.
                    if ((SAT != 0) && w_add_ovf) begin
                        w_acc_nxt = r_acc[n-1] ? SatMin : SatMax;
                    end else begin
                        w_acc_nxt = w_sum;
                    end
                    w_cout_nxt       = w_add_cout;
                    w_overflow_nxt   = w_add_ovf;
                    w_ovf_sticky_nxt = r_ovf_sticky | w_add_ovf;
                    if (r_op_count != CntMax) begin
                        w_op_count_nxt = r_op_count + 1'b1;
                    end
                end
                OP_LOAD: begin
                    w_acc_nxt        = y;
                    w_cout_nxt       = 1'b0;
                    w_overflow_nxt   = 1'b0;
                    w_ovf_sticky_nxt = 1'b0;
                    w_op_count_nxt   = '0;
                end
                default: begin
                    w_acc_nxt        = '0;
                    w_cout_nxt       = 1'b0;
                    w_overflow_nxt   = 1'b0;
                    w_ovf_sticky_nxt = 1'b0;
                    w_op_count_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_out_valid_nxt = r_out_valid;
        if (w_accept) begin
            w_out_valid_nxt = 1'b1;
        end else if (out_ready) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_acc        <= '0;
            r_cout       <= 1'b0;
            r_overflow   <= 1'b0;
            r_ovf_sticky <= 1'b0;
            r_op_count   <= '0;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_acc        <= w_acc_nxt;
            r_cout       <= w_cout_nxt;
            r_overflow   <= w_overflow_nxt;
            r_ovf_sticky <= w_ovf_sticky_nxt;
            r_op_count   <= w_op_count_nxt;
        end
    end

    assign out_valid  = r_out_valid;
    assign acc        = r_acc;
    assign cout       = r_cout;
    assign overflow   = r_overflow;
    assign ovf_sticky = r_ovf_sticky;
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed bench: one wrapping and one saturating instance driven in lockstep.
module tb_addsub_accumulator;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] SUB = 2'b01;
    localparam logic [1:0] LD  = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] op;
    logic [7:0] y;
    logic       out_ready;

    logic       w_in_ready,  s_in_ready;
    logic       w_out_valid, s_out_valid;
    logic [7:0] w_acc,       s_acc;
    logic       w_cout,      s_cout;
    logic       w_ovf,       s_ovf;
    logic       w_sticky,    s_sticky;
    logic [7:0] w_cnt,       s_cnt;

    int n_cmp;
    int n_fail;

    addsub_accumulator #(.n(8), .SAT(0), .CNT_W(8)) u_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (w_in_ready),
        .op         (op),
        .y          (y),
        .out_valid  (w_out_valid),
        .out_ready  (out_ready),
        .acc        (w_acc),
        .cout       (w_cout),
        .overflow   (w_ovf),
        .ovf_sticky (w_sticky),
        .op_count   (w_cnt)
    );

    addsub_accumulator #(.n(8), .SAT(1), .CNT_W(8)) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .op         (op),
        .y          (y),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .acc        (s_acc),
        .cout       (s_cout),
        .overflow   (s_ovf),
        .ovf_sticky (s_sticky),
        .op_count   (s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] y;
        logic       vld;
        logic [7:0] e_acc;
        logic       e_cout;
        logic       e_ovf;
        logic       e_sticky;
        logic [7:0] e_cnt;
        logic       e_valid;
        logic [7:0] e_sat_acc;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic [7:0] d,
                         input logic rdy);
        in_valid  = v;
        op        = o;
        y         = d;
        out_ready = rdy;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive(1'b0, ADD, 8'h00, 1'b1);

        //          op   y      v  acc    c  o  s  cnt    val sat_acc
        vecs[0]  = '{LD,  8'h05, 1, 8'h05, 0, 0, 0, 8'd0, 1, 8'h05};
        vecs[1]  = '{ADD, 8'h03, 1, 8'h08, 0, 0, 0, 8'd1, 1, 8'h08};
        vecs[2]  = '{LD,  8'h7F, 1, 8'h7F, 0, 0, 0, 8'd0, 1, 8'h7F};
        vecs[3]  = '{ADD, 8'h01, 1, 8'h80, 0, 1, 1, 8'd1, 1, 8'h7F};
        vecs[4]  = '{ADD, 8'h01, 1, 8'h81, 0, 0, 1, 8'd2, 1, 8'h7F};
        vecs[5]  = '{SUB, 8'h01, 1, 8'h80, 1, 0, 1, 8'd3, 1, 8'h7E};
        vecs[6]  = '{ADD, 8'hFF, 1, 8'h7F, 1, 1, 1, 8'd4, 1, 8'h7D};
        vecs[7]  = '{SUB, 8'h80, 1, 8'hFF, 0, 1, 1, 8'd5, 1, 8'h7F};
        vecs[8]  = '{CLR, 8'hAA, 1, 8'h00, 0, 0, 0, 8'd0, 1, 8'h00};
        vecs[9]  = '{SUB, 8'h00, 1, 8'h00, 1, 0, 0, 8'd1, 1, 8'h00};
        vecs[10] = '{ADD, 8'h44, 0, 8'h00, 1, 0, 0, 8'd1, 0, 8'h00};
        vecs[11] = '{LD,  8'hC3, 1, 8'hC3, 0, 0, 0, 8'd0, 1, 8'hC3};

        // Reset state
        cyc();
        cyc();
        chk("rst acc", {24'd0, w_acc}, 32'h0);
        chk("rst valid", {31'd0, w_out_valid}, 32'h0);
        chk("rst cnt", {24'd0, w_cnt}, 32'h0);
        chk("rst flags", {29'd0, w_cout, w_ovf, w_sticky}, 32'h0);
        chk("rst in_ready", {31'd0, w_in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors, one command per cycle with out_ready=1
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].vld, vecs[i].op, vecs[i].y, 1'b1);
            cyc();
            chk($sformatf("v%0d acc", i), {24'd0, w_acc}, {24'd0, vecs[i].e_acc});
            chk($sformatf("v%0d cout", i), {31'd0, w_cout}, {31'd0, vecs[i].e_cout});
            chk($sformatf("v%0d ovf", i), {31'd0, w_ovf}, {31'd0, vecs[i].e_ovf});
            chk($sformatf("v%0d sticky", i), {31'd0, w_sticky}, {31'd0, vecs[i].e_sticky});
            chk($sformatf("v%0d cnt", i), {24'd0, w_cnt}, {24'd0, vecs[i].e_cnt});
            chk($sformatf("v%0d valid", i), {31'd0, w_out_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d sat acc", i), {24'd0, s_acc}, {24'd0, vecs[i].e_sat_acc});
        end

        // Saturating subtract at the negative limit
        drive(1'b1, LD, 8'h80, 1'b1);
        cyc();
        drive(1'b1, SUB, 8'h01, 1'b1);
        cyc();
        chk("sat sub acc", {24'd0, s_acc}, 32'h80);
        chk("sat sub ovf", {31'd0, s_ovf}, 32'h1);
        chk("sat sub cout", {31'd0, s_cout}, 32'h1);
        chk("wrap sub acc", {24'd0, w_acc}, 32'h7F);
        drive(1'b1, SUB, 8'h00, 1'b1);
        cyc();
        chk("sat sub0 acc", {24'd0, s_acc}, 32'h80);
        chk("sat sub0 cout", {31'd0, s_cout}, 32'h1);
        chk("sat sub0 ovf", {31'd0, s_ovf}, 32'h0);
        chk("sat sub0 sticky", {31'd0, s_sticky}, 32'h1);

        // Back-pressure: hold result for 5 cycles, then drain and accept together
        drive(1'b1, LD, 8'h11, 1'b1);
        cyc();
        drive(1'b1, ADD, 8'h22, 1'b0);
        #1;
        chk("bp in_ready low", {31'd0, w_in_ready}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("bp%0d acc", i), {24'd0, w_acc}, 32'h11);
            chk($sformatf("bp%0d valid", i), {31'd0, w_out_valid}, 32'h1);
            chk($sformatf("bp%0d in_ready", i), {31'd0, w_in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp in_ready comb", {31'd0, w_in_ready}, 32'h1);
        cyc();
        chk("bp drain acc", {24'd0, w_acc}, 32'h33);
        chk("bp drain valid", {31'd0, w_out_valid}, 32'h1);
        chk("bp drain cnt", {24'd0, w_cnt}, 32'h1);
        drive(1'b0, ADD, 8'h00, 1'b1);
        cyc();
        chk("bp empty valid", {31'd0, w_out_valid}, 32'h0);

        // Counter saturation across 300 ADDs, first one overflowing
        drive(1'b1, LD, 8'h7F, 1'b1);
        cyc();
        drive(1'b1, ADD, 8'h01, 1'b1);
        cyc();
        drive(1'b1, ADD, 8'h00, 1'b1);
        for (int i = 1; i < 300; i++) begin
            cyc();
            if (i == 254) begin
                chk("cnt at 255", {24'd0, w_cnt}, 32'hFF);
            end
        end
        chk("cnt held", {24'd0, w_cnt}, 32'hFF);
        chk("cnt sticky", {31'd0, w_sticky}, 32'h1);
        drive(1'b1, CLR, 8'h5C, 1'b1);
        cyc();
        chk("clr cnt", {24'd0, w_cnt}, 32'h0);
        chk("clr acc", {24'd0, w_acc}, 32'h0);
        chk("clr sticky", {31'd0, w_sticky}, 32'h0);

        // Reset while a result is pending
        drive(1'b1, LD, 8'h5A, 1'b0);
        cyc();
        drive(1'b0, ADD, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid rst acc", {24'd0, w_acc}, 32'h0);
        chk("mid rst valid", {31'd0, w_out_valid}, 32'h0);
        chk("mid rst cnt", {24'd0, w_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post rst in_ready", {31'd0, w_in_ready}, 32'h1);
        drive(1'b1, ADD, 8'h03, 1'b1);
        cyc();
        chk("post rst acc", {24'd0, w_acc}, 32'h03);
        chk("post rst cnt", {24'd0, w_cnt}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
